// File: rtl/osc_seq_pkg.sv
// Shared types and constants for the oscillator step sequencer.
package osc_seq_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PLAY     = 2'd1,
    STOPPING = 2'd2
  } seq_state_t;

  localparam int REST_PITCH = 0;

endpackage

// File: rtl/osc_step_timer.sv
// Step timer: tick counter plus the tempo/gate lengths latched at each step load.
module step_timer #(
  parameter int TEMPO_W = 24
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               advance,
  input  logic               clear,
  input  logic [TEMPO_W-1:0] tempo_div,
  input  logic [TEMPO_W-1:0] gate_len,
  output logic               step_end,
  output logic               gate_win_load,
  output logic               gate_win_next
);

  logic [TEMPO_W-1:0] tick;
  logic [TEMPO_W-1:0] eff_tempo;
  logic [TEMPO_W-1:0] eff_gate;
  logic [TEMPO_W:0]   tick_inc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick      <= '0;
      eff_tempo <= TEMPO_W'(1);
      eff_gate  <= '0;
    end else if (load) begin
      tick      <= '0;
      eff_tempo <= (tempo_div == '0) ? TEMPO_W'(1) : tempo_div;
      eff_gate  <= gate_len;
    end else if (clear) begin
      tick <= '0;
    end else if (advance) begin
      tick <= tick_inc[TEMPO_W-1:0];
    end
  end

  // tick can run past eff_tempo-1 while a legato gate drains in STOPPING,
  // so the end-of-step compare is >= rather than ==.
  always_comb begin
    tick_inc      = {1'b0, tick} + {{TEMPO_W{1'b0}}, 1'b1};
    step_end      = (tick >= (eff_tempo - TEMPO_W'(1)));
    gate_win_next = (tick_inc < {1'b0, eff_gate});
    gate_win_load = (gate_len != '0);
  end

endmodule

// File: rtl/osc_step_sequencer.sv
// Tempo-locked pitch sequencer driving the oscillator counter_top and reset
// from a STEPS-entry table written by the user-input front end.
module osc_step_sequencer
  import osc_seq_pkg::*;
#(
  parameter  int STEPS   = 8,
  parameter  int PITCH_W = 16,
  parameter  int TEMPO_W = 24,
  localparam int IDX_W   = $clog2(STEPS)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               run,
  input  logic [TEMPO_W-1:0] tempo_div,
  input  logic [TEMPO_W-1:0] gate_len,
  input  logic               wr_en,
  input  logic [IDX_W-1:0]   wr_addr,
  input  logic [PITCH_W-1:0] wr_pitch,
  output logic [PITCH_W-1:0] counter_top,
  output logic               osc_rst,
  output logic               gate,
  output logic [IDX_W-1:0]   step_idx,
  output logic               step_strobe
);

  seq_state_t         state, state_nxt;
  logic [PITCH_W-1:0] step_tab [STEPS];
  logic               cur_rest, cur_rest_nxt;
  logic [PITCH_W-1:0] counter_top_nxt;
  logic [IDX_W-1:0]   step_idx_nxt;
  logic               gate_nxt;
  logic               strobe_nxt;
  logic [IDX_W-1:0]   load_idx;
  logic [PITCH_W-1:0] load_pitch;
  logic               load_rest;
  logic               load_req;
  logic               gate_cont;
  logic               tmr_load, tmr_adv, tmr_clr;
  logic               step_end, gate_win_load, gate_win_next;

  step_timer #(.TEMPO_W(TEMPO_W)) u_timer (
    .clk          (clk),
    .rst_n        (rst_n),
    .load         (tmr_load),
    .advance      (tmr_adv),
    .clear        (tmr_clr),
    .tempo_div    (tempo_div),
    .gate_len     (gate_len),
    .step_end     (step_end),
    .gate_win_load(gate_win_load),
    .gate_win_next(gate_win_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STEPS; i++) step_tab[i] <= '0;
    end else if (wr_en) begin
      step_tab[wr_addr] <= wr_pitch;
    end
  end

  // Write-first bypass: a write landing on the entry being loaded wins.
  always_comb begin
    load_idx   = (state == IDLE) ? '0 : step_idx + IDX_W'(1);
    load_pitch = (wr_en && (wr_addr == load_idx)) ? wr_pitch : step_tab[load_idx];
    load_rest  = (load_pitch == PITCH_W'(REST_PITCH));
    gate_cont  = gate_win_next && !cur_rest;
  end

  always_comb begin
    state_nxt       = state;
    counter_top_nxt = counter_top;
    step_idx_nxt    = step_idx;
    gate_nxt        = gate;
    strobe_nxt      = 1'b0;
    cur_rest_nxt    = cur_rest;
    load_req        = 1'b0;
    tmr_load        = 1'b0;
    tmr_adv         = 1'b0;
    tmr_clr         = 1'b0;
    case (state)
      IDLE: begin
        gate_nxt = 1'b0;
        if (run) load_req = 1'b1;
      end
      PLAY, STOPPING: begin
        if (run) begin
          state_nxt = PLAY;
          if (step_end) begin
            load_req = 1'b1;
          end else begin
            tmr_adv  = 1'b1;
            gate_nxt = gate_cont;
          end
        end else if (gate_cont) begin
          state_nxt = STOPPING;
          tmr_adv   = 1'b1;
          gate_nxt  = 1'b1;
        end else begin
          state_nxt = IDLE;
          tmr_clr   = 1'b1;
          gate_nxt  = 1'b0;
        end
      end
      default: begin
        state_nxt = IDLE;
        gate_nxt  = 1'b0;
      end
    endcase
    // Rest entries keep the previous counter_top so the oscillator never glitches.
    if (load_req) begin
      state_nxt    = PLAY;
      tmr_load     = 1'b1;
      step_idx_nxt = load_idx;
      strobe_nxt   = 1'b1;
      cur_rest_nxt = load_rest;
      gate_nxt     = gate_win_load && !load_rest;
      if (!load_rest) counter_top_nxt = load_pitch;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      counter_top <= '0;
      step_idx    <= '0;
      gate        <= 1'b0;
      osc_rst     <= 1'b1;
      step_strobe <= 1'b0;
      cur_rest    <= 1'b1;
    end else begin
      state       <= state_nxt;
      counter_top <= counter_top_nxt;
      step_idx    <= step_idx_nxt;
      gate        <= gate_nxt;
      osc_rst     <= ~gate_nxt;
      step_strobe <= strobe_nxt;
      cur_rest    <= cur_rest_nxt;
    end
  end

endmodule

// File: tb/tb_osc_step_sequencer.sv
// Scoreboard bench for osc_step_sequencer: stimulus queues per-cycle expectations,
// a monitor pops and compares them shortly after each rising edge.
module tb_osc_step_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        run;
  logic [23:0] tempo_div;
  logic [23:0] gate_len;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [15:0] wr_pitch;
  logic [15:0] counter_top;
  logic        osc_rst;
  logic        gate;
  logic [2:0]  step_idx;
  logic        step_strobe;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic        g;
    logic [2:0]  idx;
    logic [15:0] ct;
    logic        stb;
  } exp_t;

  exp_t exp_q[$];

  osc_step_sequencer #(.STEPS(8), .PITCH_W(16), .TEMPO_W(24)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .run        (run),
    .tempo_div  (tempo_div),
    .gate_len   (gate_len),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_pitch   (wr_pitch),
    .counter_top(counter_top),
    .osc_rst    (osc_rst),
    .gate       (gate),
    .step_idx   (step_idx),
    .step_strobe(step_strobe)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor
  initial begin
    exp_t e;
    logic ng;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        ng = ~e.g;
        chk("gate", {31'd0, gate}, {31'd0, e.g});
        chk("osc_rst", {31'd0, osc_rst}, {31'd0, ng});
        chk("step_idx", {29'd0, step_idx}, {29'd0, e.idx});
        chk("counter_top", {16'd0, counter_top}, {16'd0, e.ct});
        chk("step_strobe", {31'd0, step_strobe}, {31'd0, e.stb});
      end
    end
  end

  task automatic cyc(input logic g, input int idx, input int ct, input logic stb);
    exp_t e;
    e.g   = g;
    e.idx = idx[2:0];
    e.ct  = ct[15:0];
    e.stb = stb;
    exp_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic play_step(input int idx, input int ct, input logic [3:0] pat);
    for (int t = 0; t < 4; t++) cyc(pat[3-t], idx, ct, (t == 0));
  endtask

  task automatic wr(input int a, input int p);
    wr_en    = 1'b1;
    wr_addr  = a[2:0];
    wr_pitch = p[15:0];
    @(posedge clk);
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  int          wrap_ct [9] = '{100, 200, 200, 400, 500, 600, 700, 800, 100};
  logic [8:0]  wrap_g      = 9'b110111111;
  int          full_ct [8] = '{100, 200, 300, 400, 500, 600, 700, 800};
  int          init_pitch [8] = '{100, 200, 0, 400, 500, 600, 700, 800};

  initial begin
    rst_n = 1'b0; run = 1'b0; tempo_div = 24'd4; gate_len = 24'd2;
    wr_en = 1'b0; wr_addr = '0; wr_pitch = '0;
    #12;
    chk("rst_counter_top", {16'd0, counter_top}, 32'd0);
    chk("rst_osc_rst", {31'd0, osc_rst}, 32'd1);
    chk("rst_gate", {31'd0, gate}, 32'd0);
    chk("rst_step_idx", {29'd0, step_idx}, 32'd0);
    chk("rst_step_strobe", {31'd0, step_strobe}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(1);
    for (int i = 0; i < 8; i++) wr(i, init_pitch[i]);

    // Basic sequence with a rest step
    run = 1'b1;
    play_step(0, 100, 4'b1100);
    play_step(1, 200, 4'b1100);
    play_step(2, 200, 4'b0000);
    play_step(3, 400, 4'b1100);
    run = 1'b0;
    cyc(0, 3, 400, 0);
    cyc(0, 3, 400, 0);

    // Stop mid-step with gate_len 3, then restart
    gate_len = 24'd3; run = 1'b1;
    play_step(0, 100, 4'b1110);
    play_step(1, 200, 4'b1110);
    play_step(2, 200, 4'b0000);
    cyc(1, 3, 400, 1);
    cyc(1, 3, 400, 0);
    run = 1'b0;
    cyc(1, 3, 400, 0);
    cyc(0, 3, 400, 0);
    cyc(0, 3, 400, 0);
    run = 1'b1;
    cyc(1, 0, 100, 1);
    run = 1'b0;
    cyc(1, 0, 100, 0);
    run = 1'b1;
    cyc(1, 0, 100, 0);
    cyc(0, 0, 100, 0);
    cyc(1, 1, 200, 1);
    run = 1'b0;
    cyc(1, 1, 200, 0);
    cyc(1, 1, 200, 0);
    cyc(0, 1, 200, 0);

    // tempo_div 1 then 0: one step per clock, strobe held high
    gate_len = 24'd1;
    for (int k = 0; k < 2; k++) begin
      tempo_div = (k == 0) ? 24'd1 : 24'd0;
      run = 1'b1;
      for (int i = 0; i < 9; i++) cyc(wrap_g[8-i], i % 8, wrap_ct[i], 1);
      run = 1'b0;
      cyc(0, 0, 100, 0);
    end

    // Legato across 16 steps
    wr(2, 300);
    tempo_div = 24'd4; gate_len = 24'd10; run = 1'b1;
    for (int s = 0; s < 16; s++) play_step(s % 8, full_ct[s % 8], 4'b1111);
    run = 1'b0;
    for (int i = 0; i < 6; i++) cyc(1, 7, 800, 0);
    cyc(0, 7, 800, 0);

    // Write-first on load, then mid-step write deferred to next load
    gate_len = 24'd2; run = 1'b1;
    play_step(0, 100, 4'b1100);
    play_step(1, 200, 4'b1100);
    wr_en = 1'b1; wr_addr = 3'd2; wr_pitch = 16'd777;
    cyc(1, 2, 777, 1);
    wr_pitch = 16'd555;
    cyc(1, 2, 777, 0);
    wr_en = 1'b0;
    cyc(0, 2, 777, 0);
    cyc(0, 2, 777, 0);
    for (int s = 3; s < 10; s++) play_step(s % 8, full_ct[s % 8], 4'b1100);
    cyc(1, 2, 555, 1);
    run = 1'b0;
    cyc(1, 2, 555, 0);
    cyc(0, 2, 555, 0);

    // Asynchronous reset mid-step
    run = 1'b1;
    cyc(1, 0, 100, 1);
    cyc(1, 0, 100, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_counter_top", {16'd0, counter_top}, 32'd0);
    chk("arst_osc_rst", {31'd0, osc_rst}, 32'd1);
    chk("arst_gate", {31'd0, gate}, 32'd0);
    chk("arst_step_idx", {29'd0, step_idx}, 32'd0);
    chk("arst_step_strobe", {31'd0, step_strobe}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    play_step(0, 0, 4'b0000);
    play_step(1, 0, 4'b0000);
    run = 1'b0;
    idle(3);

    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/osc_step_sequencer.md
Name: osc_step_sequencer

Overview:
Pitch sequencer that drives the oscillator's counter_top and rst inputs from a small step table, turning the free-running tone into a tempo-locked melody. It holds STEPS pitch entries, which a button/scan front end writes through a simple write port. It advances one entry per tempo period and gates the oscillator per step. It sits between the user-input logic and the oscillator instance in top.

Parameters:
STEPS, 8, number of table entries (power of two, 2..32)
PITCH_W, 16, width of counter_top driven to the oscillator
TEMPO_W, 24, width of the tempo and gate-length counters
IDX_W, $clog2(STEPS), step index width (derived, not overridden)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
run  in  1  level; high = play, low = stop after current step's gate
tempo_div  in  TEMPO_W  clocks per step; 0 treated as 1
gate_len  in  TEMPO_W  clocks the gate stays high within a step; >= effective tempo_div = legato
wr_en  in  1  table write strobe
wr_addr  in  IDX_W  table write address
wr_pitch  in  PITCH_W  pitch (counter_top) value; 0 = rest
counter_top  out  PITCH_W  to oscillator counter_top
osc_rst  out  1  to oscillator rst; high silences the oscillator
gate  out  1  note-on indicator
step_idx  out  IDX_W  currently playing step
step_strobe  out  1  one-cycle pulse on each step load

Behaviour:
- Reset (async, rst_n low): state IDLE; all table entries 0; counter_top 0, osc_rst 1, gate 0, step_idx 0, step_strobe 0, tick 0.
- All outputs registered. osc_rst = ~gate at all times.
- States: IDLE, PLAY, STOPPING.
- IDLE: run high at edge N -> PLAY at N+1 with step_idx 0, counter_top = table[0], step_strobe 1, tick 0.
- Latch: tempo_div and gate_len are latched as eff_tempo and eff_gate at every step load. Changes mid-step do not affect the current step.
- PLAY: tick increments every clock. At tick == eff_tempo-1 the next edge does all of the following: tick 0, step_idx+1 (wraps STEPS-1 -> 0), counter_top loads the new entry, step_strobe 1.
- Gate: gate = (tick < eff_gate) && (entry != 0), evaluated so gate is high in the load cycle.
  - eff_gate == 0: gate never rises.
  - eff_gate >= eff_tempo with a non-rest entry followed by a non-rest entry: gate stays continuously high across the boundary (no one-cycle drop).
- Rest steps: a rest step (pitch 0) holds the previous counter_top, so there is no glitch at the oscillator, and gate stays low.
- Stop: run low in PLAY -> STOPPING.
  - STOPPING continues tick counting without advancing. When gate would fall (tick reaches eff_gate, or immediately if gate already low), go to IDLE.
  - On entering IDLE: gate 0, counter_top and step_idx hold their values.
  - run high again in STOPPING -> back to PLAY with no step reload.
  - Restart from IDLE always begins at step 0.
- tempo_div == 1: new step every clock. step_strobe is held high continuously.
- Writes: take effect at the next edge.
  - A write to the step being played does not alter counter_top until that step is next loaded.
  - A write to the address being loaded on the same edge is write-first: the new data is loaded.
- Reset mid-play: immediate return to reset values, table cleared.

Decomposition:
- Package osc_seq_pkg: state enum (IDLE/PLAY/STOPPING) and the REST_PITCH constant (0).
- Sub-module step_timer holds the tick counter, latched eff_tempo/eff_gate, tempo-0 clamp, and the end-of-step and gate-window compare outputs.
- Table storage and the FSM stay in osc_step_sequencer.

Test Plan:
- Reset then table {100,200,0,400,...}, tempo_div=4, gate_len=2, run=1 -> strobes every 4 clocks. counter_top sequence 100,200,200,400. gate pattern 1100,1100,0000,1100. osc_rst = ~gate.
- Wrap and rate: STEPS=8, tempo_div=1 -> step_idx 0..7,0 on consecutive clocks. step_strobe constant high. tempo_div=0 gives identical output.
- Legato: gate_len=10, tempo_div=4, all entries nonzero -> gate stays high with no low cycle across 16 steps.
- Stop/restart: drop run at tick 1 of step 3 with gate_len=3 -> gate falls at tick 3, state IDLE, step_idx stays 3. Re-raise run -> step_idx 0, counter_top = table[0] one clock later.
- Write-first: write table[2]=777 on the same edge step 2 loads -> counter_top=777. Write table[2]=555 mid-step 2 -> counter_top stays 777 until step 2 is next loaded.
- Async reset: assert rst_n low mid-step, off-edge -> outputs go to reset values immediately. Table reads back all rests, so gate stays 0 after restart.
